register_bank: RTL

- 32-entry x DATA_WIDTH general-purpose register file; the consumer end of the write-back interface.
- Accepts the write-back stage's selected result plus destination index and write enable.
- Serves two combinational read ports (rs/rt) to the decode stage.
- Includes a handshaked dump engine that streams all registers to the debug unit, one register per accepted beat.

---
 rtl/register_bank_pkg.sv | 21 ++
 rtl/register_dump_ctrl.sv | 78 +++++++
 rtl/register_bank.sv | 93 +++++++++
 3 files changed

// File: rtl/register_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module : register_bank_pkg
// Brief  : Shared constants and dump-engine state encoding for register_bank.
// Rev    : 1.0
// ============================================================================
package register_bank_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 5;
   localparam int REG_DEPTH          = 2 ** DEFAULT_ADDR_WIDTH;
   localparam int REG_ZERO           = 0;

   typedef enum logic [1:0] {
      DUMP_IDLE = 2'd0,
      DUMP_SEND = 2'd1,
      DUMP_DONE = 2'd2
   } dump_state_e;

endpackage
`default_nettype wire

// File: rtl/register_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module : register_dump_ctrl
// Brief  : Handshaked dump sequencer; walks every register index once per dump.
// Rev    : 1.0
// ============================================================================
module register_dump_ctrl
   import register_bank_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dump_start,
   input  logic                  dump_ready,
   output logic                  dump_valid,
   output logic                  dump_busy,
   output logic                  dump_done,
   output logic [ADDR_WIDTH-1:0] dump_idx
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

   dump_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DUMP_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dump_valid = 1'b0;
      dump_busy  = 1'b0;
      dump_done  = 1'b0;
      case (state_q)
         DUMP_IDLE: begin
            if (dump_start) begin
               state_d = DUMP_SEND;
               cnt_d   = '0;
            end
         end
         DUMP_SEND: begin
            dump_valid = 1'b1;
            dump_busy  = 1'b1;
            // The counter parks on the last index so it can never wrap.
            if (dump_ready) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = DUMP_DONE;
               end else begin
                  cnt_d = cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         DUMP_DONE: begin
            dump_done = 1'b1;
            dump_busy = 1'b1;
            state_d   = DUMP_IDLE;
            cnt_d     = '0;
         end
         default: begin
            state_d = DUMP_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign dump_idx = cnt_q;

endmodule
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
// Module : register_bank
// Brief  : 32 x DATA_WIDTH register file, two async read ports, dump streamer.
//          Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Rev    : 1.0
// ============================================================================
module register_bank
   import register_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_we,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   output logic [DATA_WIDTH-1:0] rs_data,
   output logic [DATA_WIDTH-1:0] rt_data,
   input  logic                  dump_start,
   input  logic                  dump_ready,
   output logic                  dump_valid,
   output logic [ADDR_WIDTH-1:0] dump_idx,
   output logic [DATA_WIDTH-1:0] dump_data,
   output logic                  dump_busy,
   output logic                  dump_done
);

   localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];
   logic [DATA_WIDTH-1:0] dump_word;
   logic                  wb_wr_en;

   assign wb_wr_en = wb_we && (wb_addr != ZERO_IDX);

   register_dump_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_dump_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .dump_valid (dump_valid),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done),
      .dump_idx   (dump_idx)
   );

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wb_wr_en) begin
         regs_d[wb_addr] = wb_data;
      end
      regs_d[REG_ZERO] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      rs_data   = regs_q[rs_addr];
      rt_data   = regs_q[rt_addr];
      dump_word = regs_q[dump_idx];
`ifdef REGFILE_BYPASS_EN
      if (wb_wr_en && (wb_addr == rs_addr)) rs_data   = wb_data;
      if (wb_wr_en && (wb_addr == rt_addr)) rt_data   = wb_data;
      if (wb_wr_en && (wb_addr == dump_idx)) dump_word = wb_data;
`endif
      if (rs_addr == ZERO_IDX) rs_data = '0;
      if (rt_addr == ZERO_IDX) rt_data = '0;
      // Beat data is only meaningful while a beat is offered.
      dump_data = dump_valid ? dump_word : '0;
   end

endmodule
`default_nettype wire
